// File: rtl/imem_loader.sv
// Streams host bytes into the instruction store through a byte write port, little-endian.
// Optional trailing checksum byte is enabled with `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DEPTH  = 80,
    parameter int unsigned LEN_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len_words,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = LEN_W + 2;
    localparam int unsigned SPAN_W = ADDR_W + 3;

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, end_q;
    logic [ADDR_W-1:0] addr_q;
    logic [SPAN_W-1:0] span;
    logic              start_ok, load_go, accept, data_acc, finish;
    logic              done_set, err_set;

    // Range check is done wide enough that base + 4*len can never wrap.
    assign span     = SPAN_W'(base_addr) + SPAN_W'({len_words, 2'b00});
    assign start_ok = (base_addr[1:0] == 2'b00) && (span <= SPAN_W'(DEPTH));
    assign load_go  = (state_q == StIdle) && start && start_ok;
    assign accept   = in_valid && in_ready;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       sum_ok_q;
    logic       in_csum;

    // Once all data bytes are in, the next accepted byte is the checksum.
    assign in_csum  = (cnt_q == end_q);
    assign data_acc = accept && !in_csum;
    assign finish   = accept && in_csum;
    assign done_set = (state_q == StDone) && sum_ok_q;
    assign err_set  = ((state_q == StIdle) && start && !start_ok) ||
                      ((state_q == StDone) && !sum_ok_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q    <= 8'h00;
            sum_ok_q <= 1'b0;
        end else begin
            if (load_go) begin
                sum_q <= 8'h00;
            end else if (data_acc) begin
                sum_q <= sum_q + in_data;
            end
            if (finish) begin
                sum_ok_q <= ((sum_q + in_data) == 8'h00);
            end
        end
    end
`else
    assign data_acc = accept;
    assign finish   = accept && ((cnt_q + CNT_W'(1)) == end_q);
    assign done_set = (state_q == StDone);
    assign err_set  = (state_q == StIdle) && start && !start_ok;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (load_go) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = StLoad;
`else
                    state_d = (len_words == '0) ? StDone : StLoad;
`endif
                end
            end
            StLoad: begin
                if (finish) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready = (state_q == StLoad);
        busy     = (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            end_q   <= '0;
            addr_q  <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'h00;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            wr_en <= data_acc;
            done  <= done_set;
            err   <= err_set;
            if (data_acc) begin
                wr_addr <= addr_q;
                wr_data <= in_data;
                addr_q  <= addr_q + ADDR_W'(1);
                cnt_q   <= cnt_q + CNT_W'(1);
            end
            if (load_go) begin
                cnt_q  <= '0;
                addr_q <= base_addr;
                end_q  <= {len_words, 2'b00};
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader; writes and done/err pulses are predicted by a
// byte-level load model and checked by an independent monitor.
module tb_imem_loader;

    localparam int ADDR_W = 7;
    localparam int DEPTH  = 80;
    localparam int LEN_W  = 5;

    logic              clk = 1'b0;
    logic              reset, start, in_valid;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  len_words;
    logic [7:0]        in_data;
    logic              in_ready, wr_en, busy, done, err;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .len_words(len_words), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {int addr; int data; int cyc;} wr_t;
    typedef struct {bit is_err; int cyc;} ev_t;
    wr_t wq[$];
    ev_t evq[$];
    wr_t we;
    ev_t ee;

    byte unsigned tb_mem[DEPTH];
    byte unsigned ref_mem[DEPTH];
    byte unsigned byte_q[$];
    bit           vpat[$];
    bit           mid_start = 1'b0;
    bit           csum_force = 1'b0;
    byte unsigned csum_val = 8'h00;
    int           last_wr = -1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (wq.size() == 0) begin
                check("spurious_write", 1, 0);
            end else begin
                we = wq.pop_front();
                check("wr_addr", int'(wr_addr), we.addr);
                check("wr_data", int'(wr_data), we.data);
                check("wr_cycle", cyc, we.cyc);
            end
            if (int'(wr_addr) < DEPTH) tb_mem[wr_addr] = wr_data;
            last_wr = int'(wr_addr);
        end
        if (done === 1'b1 || err === 1'b1) begin
            if (done === 1'b1 && err === 1'b1) check("done_and_err", 1, 0);
            if (evq.size() == 0) begin
                check("spurious_event", 1, 0);
            end else begin
                ee = evq.pop_front();
                check("event_is_err", int'(err), int'(ee.is_err));
                check("event_cycle", cyc, ee.cyc);
            end
        end
    end

    task automatic do_load(input int base, input int len);
        int c, n, nd, i, guard, sum;
        bit ok, v;
        byte unsigned b;
        ok = (base % 4 == 0) && (base + 4 * len <= DEPTH);
        @(posedge clk); #1;
        start = 1'b1; base_addr = ADDR_W'(base); len_words = LEN_W'(len); c = cyc;
        if (!ok) evq.push_back('{1'b1, c + 1});
        @(posedge clk); #1;
        start = 1'b0;
        if (!ok) begin
            check("rej_busy", int'(busy), 0);
            check("rej_ready", int'(in_ready), 0);
            byte_q.delete(); vpat.delete();
            repeat (2) @(posedge clk);
            return;
        end
        nd = 4 * len;
`ifdef IMEM_LOADER_CHECKSUM_EN
        n = nd + 1;
`else
        n = nd;
`endif
        if (n == 0) begin
            evq.push_back('{1'b0, c + 2});
            check("zero_busy", int'(busy), 1);
            check("zero_ready", int'(in_ready), 0);
            @(posedge clk); #1;
            check("zero_idle", int'(busy), 0);
            byte_q.delete(); vpat.delete();
            return;
        end
        i = 0; sum = 0; guard = 0;
        while (i < n && guard < 1000) begin
            guard++;
            v = (vpat.size() != 0) ? vpat.pop_front() : ($urandom % 4 != 0);
            if (i < nd) b = (byte_q.size() != 0) ? byte_q.pop_front() : 8'($urandom);
            else        b = csum_force ? csum_val : 8'((256 - (sum % 256)) % 256);
            in_valid = v;
            in_data  = v ? b : 8'($urandom);
            start    = mid_start && (i == 1);
            if (mid_start) base_addr = ADDR_W'($urandom);
            check("in_ready_load", int'(in_ready), 1);
            check("busy_load", int'(busy), 1);
            if (v) begin
                if (i < nd) begin
                    wq.push_back('{base + i, int'(b), cyc + 1});
                    ref_mem[base + i] = b;
                    sum += int'(b);
                    if (i == n - 1) evq.push_back('{1'b0, cyc + 2});
                end else begin
                    evq.push_back('{((sum + int'(b)) % 256) != 0, cyc + 2});
                end
                i++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; start = 1'b0;
        check("ready_drop", int'(in_ready), 0);
        check("busy_in_done", int'(busy), 1);
        @(posedge clk); #1;
        check("busy_clear", int'(busy), 0);
        byte_q.delete(); vpat.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        byte unsigned b;
        logic [31:0] w0;
        for (int k = 0; k < DEPTH; k++) begin tb_mem[k] = 8'h00; ref_mem[k] = 8'h00; end
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        base_addr = '0; len_words = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        reset = 1'b0;

        // Basic load with in_valid held high.
        byte_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        vpat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_load(0, 2);
        w0 = {tb_mem[3], tb_mem[2], tb_mem[1], tb_mem[0]};
        check("word0", int'(w0), 32'h00500013);

        // Stalled stream.
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_load(16, 1);

        // Rejected starts.
        do_load(2, 1);
        do_load(76, 2);

        // Top-of-memory boundary, zero length, start pulsed mid-load.
        do_load(76, 1);
        check("last_addr", last_wr, DEPTH - 1);
        do_load(0, 0);
        mid_start = 1'b1;
        do_load(20, 3);
        mid_start = 1'b0;

        // Reset after the 3rd accepted byte; the byte offered during reset must not land.
        @(posedge clk); #1;
        start = 1'b1; base_addr = '0; len_words = LEN_W'(2);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            in_valid = 1'b1; in_data = b;
            check("rst_load_ready", int'(in_ready), 1);
            wq.push_back('{k, int'(b), cyc + 1});
            ref_mem[k] = b;
            @(posedge clk); #1;
        end
        reset = 1'b1; in_data = 8'($urandom);
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(in_ready), 0);
        check("midrst_wr_en", int'(wr_en), 0);
        repeat (3) @(posedge clk);
        do_load(40, 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_force = 1'b1;
        csum_val = 8'hF6;
        byte_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_load(0, 1);
        csum_val = 8'hF5;
        byte_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_load(0, 1);
        csum_force = 1'b0;
`endif

        // Randomized loads, including some misaligned or oversized requests.
        repeat (14) begin
            c = ($urandom % 4 == 0) ? int'($urandom_range(0, 127)) : 4 * int'($urandom_range(0, 19));
            do_load(c, int'($urandom_range(0, 8)));
        end

        repeat (4) @(posedge clk);
        #1;
        check("writes_pending", wq.size(), 0);
        check("events_pending", evq.size(), 0);
        for (int k = 0; k < DEPTH; k += 4) begin
            check("mem_word", int'({tb_mem[k+3], tb_mem[k+2], tb_mem[k+1], tb_mem[k]}),
                  int'({ref_mem[k+3], ref_mem[k+2], ref_mem[k+1], ref_mem[k]}));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the byte-addressed instruction memory: takes a host byte stream over a valid/ready handshake and writes it into the 80-byte (20-word) instruction store through a byte write port.
- Words are stored little-endian, so byte 0 of each word lands at the lowest address. This matches the fetch side, which reads {mem[a+3],mem[a+2],mem[a+1],mem[a]}.
- Sits between the boot/debug link and the instruction memory write port, and holds the core off (busy) while loading.

Parameters:
- ADDR_W, 7, byte-address width of the instruction memory.
- DEPTH, 80, memory size in bytes; must be a multiple of 4.
- LEN_W, 5, width of the word-count input.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- base_addr  input  ADDR_W  first byte address of the load; sampled with start.
- len_words  input  LEN_W  number of 32-bit words to load; sampled with start.
- in_valid  input  1  stream byte valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  memory byte write strobe.
- wr_addr  output  ADDR_W  memory byte address.
- wr_data  output  8  memory byte data.
- busy  output  1  high from accepted start until DONE is left.
- done  output  1  one-cycle pulse when the load completes successfully.
- err  output  1  one-cycle pulse when a start is rejected.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high, named reset.
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, state=IDLE, byte counter=0.
- States: IDLE, LOAD, DONE.
- IDLE, start=1: validity check.
  - Check: base_addr[1:0]==0 and base_addr + 4*len_words <= DEPTH, computed at ADDR_W+3 bits so there is no overflow.
  - Fail: err=1 next cycle, stay IDLE, no writes.
  - Pass, len_words=0: go to DONE directly; no writes.
  - Pass, otherwise: go to LOAD. Latch end = 4*len_words, set counter=0 and addr=base_addr.
- LOAD:
  - in_ready=1 combinationally while in LOAD.
  - A byte is accepted on any cycle with in_valid&in_ready.
  - Next cycle: wr_en=1, wr_addr=addr, wr_data=in_data. Write latency is 1 cycle from handshake.
  - On accept: addr and counter increment by 1.
  - When the accepted byte is number end-1: in_ready drops the next cycle and the state goes to DONE. That final write still issues in the same cycle as DONE entry.
  - Gaps in in_valid are allowed and produce no writes (wr_en=0 in the following cycle).
- DONE: lasts one cycle. done=1, busy=0 on the following cycle, return to IDLE.
- busy=1 in LOAD and DONE.
- start while busy: ignored, no err.
- Byte order: stream bytes k*4..k*4+3 go to addresses base+4k..base+4k+3, LSB first.
- wr_addr never exceeds DEPTH-1 (guaranteed by the start check); no wrap-around.
- Reset during LOAD: the next edge returns to IDLE with all outputs at reset values. A write already scheduled for that edge is suppressed. Partial memory contents are left as-is.
- in_valid outside LOAD: ignored; in_ready=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - After the last data byte, LOAD expects one extra checksum byte before DONE. in_ready stays high for it.
  - The checksum byte is not written; wr_en=0 for it.
  - The loader keeps an 8-bit modulo-256 sum of all data bytes.
  - If sum + checksum byte == 8'h00: done pulses as normal.
  - Otherwise: err pulses instead of done (same cycle position), then the state returns to IDLE.
  - For len_words=0: the checksum byte must be 8'h00 for done to pulse.
- When undefined: no checksum byte, no sum logic, behaviour exactly as above.

Test Plan:
- Basic load:
  - Stimulus: reset, then start with base_addr=0, len_words=2; stream bytes 13,00,50,00,93,00,10,00 with in_valid held high.
  - Response: 8 writes to addresses 0..7 with those bytes, in order, 1 cycle after each handshake.
  - Then: done pulses once; a read of word 0 returns 32'h00500013.
- Stalled stream:
  - Stimulus: base_addr=8'h10, len_words=1; in_valid toggled 1,0,0,1,1,0,1.
  - Response: exactly 4 writes to 16..19, each 1 cycle after a handshake; no wr_en on gap cycles.
- Rejected starts:
  - Stimulus: base_addr=2 (misaligned), then base_addr=76 with len_words=2 (76+8>80).
  - Response: err pulses once each; busy stays 0; no wr_en.
- Boundary and ignore cases:
  - Stimulus: base_addr=76, len_words=1.
  - Response: writes to 76..79 and done; the last address written is 79.
  - Stimulus: start with len_words=0.
  - Response: done 2 cycles after start, no writes.
  - Stimulus: start pulsed mid-load.
  - Response: ignored.
- Reset mid-load:
  - Stimulus: assert reset after the 3rd accepted byte of a 2-word load.
  - Response: next edge gives busy=0, in_ready=0, wr_en=0, and no further writes.
  - Then: a fresh start loads normally.
- Checksum (with IMEM_LOADER_CHECKSUM_EN defined):
  - Stimulus: data 01,02,03,04, then checksum F6.
  - Response: done pulses, and only 4 writes occur.
  - Stimulus: checksum F5.
  - Response: err pulses, no done.
